// File: rtl/cu_data_write_engine_control_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : cu_data_write_engine_control_mc_if
// Brief    : AFU-side write command / data / response bundle for the CU write engine.
// Revision : 1.0 - initial release
// ============================================================================
interface cu_data_write_engine_control_mc_if #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 8
);
    logic              cmd_buffer_full_in;
    logic              data_buffer_full_in;
    logic              cmd_valid_out;
    logic [ADDR_W-1:0] cmd_addr_out;
    logic [TAG_W-1:0]  cmd_tag_out;
    logic [7:0]        cmd_size_out;
    logic              wdata_valid_out;
    logic [511:0]      wdata_half0_out;
    logic [511:0]      wdata_half1_out;
    logic              resp_valid_in;
    logic              resp_ok_in;

    modport master (
        input  cmd_buffer_full_in, data_buffer_full_in, resp_valid_in, resp_ok_in,
        output cmd_valid_out, cmd_addr_out, cmd_tag_out, cmd_size_out,
               wdata_valid_out, wdata_half0_out, wdata_half1_out
    );

    modport slave (
        output cmd_buffer_full_in, data_buffer_full_in, resp_valid_in, resp_ok_in,
        input  cmd_valid_out, cmd_addr_out, cmd_tag_out, cmd_size_out,
               wdata_valid_out, wdata_half0_out, wdata_half1_out
    );
endinterface
`default_nettype wire

// File: rtl/cu_data_write_engine_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : cu_data_write_engine_control_mc
// Brief    : Round-robin multi-channel cacheline write engine with tag credits.
// Revision : 1.0 - initial release
// ============================================================================
module cu_data_write_engine_control_mc #(
    parameter int NUM_CHANNELS    = 2,
    parameter int ADDR_W          = 64,
    parameter int CNT_W           = 32,
    parameter int TAG_W           = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CL_BYTES        = 128
) (
    input  wire                         clock,
    input  wire                         rstn,
    input  wire                         enabled_in,
    input  wire                         job_start_in,
    input  wire  [ADDR_W-1:0]           job_base_addr_in,
    input  wire  [CNT_W-1:0]            job_lines_in,
    input  wire  [NUM_CHANNELS-1:0]     ch_valid_in,
    input  wire  [NUM_CHANNELS*1024-1:0] ch_data_in,
    output logic [NUM_CHANNELS-1:0]     ch_ready_out,
    cu_data_write_engine_control_mc_if.master afu,
    output logic [CNT_W-1:0]            lines_issued_out,
    output logic [CNT_W-1:0]            lines_done_out,
    output logic                        busy_out,
    output logic                        job_done_out,
    output logic                        error_out
);

    localparam int                c_PTR_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int                c_OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT   = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] c_LINE_BYTES = ADDR_W'(CL_BYTES);
    localparam logic [7:0]        c_SIZE       = 8'(CL_BYTES);
    localparam logic [c_PTR_W-1:0] c_LAST_CH   = c_PTR_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ADDR_W-1:0]    r_base;
    logic [CNT_W-1:0]     r_lines;
    logic [CNT_W-1:0]     r_issued;
    logic [CNT_W-1:0]     r_done;
    logic [c_OUT_W-1:0]   r_outstanding;
    logic                 r_error;
    logic                 r_job_done;
    logic [c_PTR_W-1:0]   r_rr_ptr;

    logic                 r_cmd_valid;
    logic [ADDR_W-1:0]    r_cmd_addr;
    logic [TAG_W-1:0]     r_cmd_tag;
    logic [7:0]           r_cmd_size;
    logic [1023:0]        r_wdata;

    logic                 w_job_accept;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_cand;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [c_PTR_W-1:0]   w_ptr_next;
    logic                 w_issue;
    logic                 w_resp_count;
    logic [1023:0]        w_sel_data;
    logic [ADDR_W-1:0]    w_next_addr;

    assign w_job_accept = (r_state == IDLE) && job_start_in && enabled_in;
    assign w_resp_count = afu.resp_valid_in && (r_state != IDLE);

    // Round-robin search starting at r_rr_ptr, which holds the channel after the last grant.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + i) % NUM_CHANNELS);
            if (!w_found && ch_valid_in[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == c_LAST_CH) ? '0 : w_grant_idx + 1'b1;

    assign w_issue = (r_state == RUN) && enabled_in &&
                     !afu.cmd_buffer_full_in && !afu.data_buffer_full_in &&
                     (r_outstanding < c_MAX_OUT) && (r_issued < r_lines) && w_found;

    always_comb begin
        ch_ready_out = '0;
        if (w_issue) begin
            ch_ready_out[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_grant_idx == c_PTR_W'(c)) begin
                w_sel_data = ch_data_in[c*1024 +: 1024];
            end
        end
    end

    assign w_next_addr = r_base + (ADDR_W'(r_issued) * c_LINE_BYTES);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_job_accept) w_state_next = (job_lines_in == '0) ? DONE : RUN;
            RUN:     if (r_issued == r_lines) w_state_next = DRAIN;
            DRAIN:   if (r_outstanding == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_base        <= '0;
            r_lines       <= '0;
            r_issued      <= '0;
            r_done        <= '0;
            r_outstanding <= '0;
            r_error       <= 1'b0;
            r_job_done    <= 1'b0;
            r_rr_ptr      <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_tag     <= '0;
            r_cmd_size    <= '0;
            r_wdata       <= '0;
        end else begin
            r_job_done  <= (r_state == DONE);
            r_cmd_size  <= c_SIZE;
            r_cmd_valid <= w_issue;
            if (w_job_accept) begin
                r_base        <= job_base_addr_in;
                r_lines       <= job_lines_in;
                r_issued      <= '0;
                r_done        <= '0;
                r_outstanding <= '0;
                r_error       <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_issued   <= r_issued + 1'b1;
                    r_cmd_addr <= w_next_addr;
                    r_cmd_tag  <= r_issued[TAG_W-1:0];
                    r_wdata    <= w_sel_data;
                    r_rr_ptr   <= w_ptr_next;
                end
                if (w_resp_count) begin
                    r_done <= r_done + 1'b1;
                    if (!afu.resp_ok_in) begin
                        r_error <= 1'b1;
                    end
                end
                // A response arriving with nothing in flight is dropped rather than underflowing.
                case ({w_issue, w_resp_count})
                    2'b10:   r_outstanding <= r_outstanding + 1'b1;
                    2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                    default: r_outstanding <= r_outstanding;
                endcase
            end
        end
    end

    assign afu.cmd_valid_out   = r_cmd_valid;
    assign afu.cmd_addr_out    = r_cmd_addr;
    assign afu.cmd_tag_out     = r_cmd_tag;
    assign afu.cmd_size_out    = r_cmd_size;
    assign afu.wdata_valid_out = r_cmd_valid;
    assign afu.wdata_half0_out = r_wdata[511:0];
    assign afu.wdata_half1_out = r_wdata[1023:512];

    assign lines_issued_out = r_issued;
    assign lines_done_out   = r_done;
    assign busy_out         = (r_state != IDLE);
    assign job_done_out     = r_job_done;
    assign error_out        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cu_data_write_engine_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_data_write_engine_control_mc
// Brief    : Directed self-checking bench for the multi-channel write engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_data_write_engine_control_mc;

    logic          clock = 1'b0;
    logic          rstn;
    logic          enabled;
    logic          job_start;
    logic          b_job_start;
    logic [63:0]   job_base;
    logic [31:0]   job_lines;
    logic [3:0]    ch_valid;
    logic [4095:0] ch_data;
    logic [3:0]    ch_ready;
    logic [1:0]    b_ready;
    logic [31:0]   lines_issued, lines_done, b_issued, b_lines_done;
    logic          busy, job_done, error, b_busy, b_job_done, b_error;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int b_done_cnt = 0;
    int b_cnt = 0;
    logic [63:0] addr_q[$];
    logic [63:0] tag_q[$];
    logic [63:0] h0_q[$];
    logic [63:0] h1_q[$];

    cu_data_write_engine_control_mc_if #(.ADDR_W(64), .TAG_W(8)) ifa ();
    cu_data_write_engine_control_mc_if #(.ADDR_W(64), .TAG_W(8)) ifb ();

    cu_data_write_engine_control_mc #(
        .NUM_CHANNELS(4), .ADDR_W(64), .CNT_W(32), .TAG_W(8),
        .MAX_OUTSTANDING(8), .CL_BYTES(128)
    ) dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled), .job_start_in(job_start),
        .job_base_addr_in(job_base), .job_lines_in(job_lines),
        .ch_valid_in(ch_valid), .ch_data_in(ch_data), .ch_ready_out(ch_ready),
        .afu(ifa.master), .lines_issued_out(lines_issued), .lines_done_out(lines_done),
        .busy_out(busy), .job_done_out(job_done), .error_out(error)
    );

    cu_data_write_engine_control_mc #(
        .NUM_CHANNELS(2), .ADDR_W(64), .CNT_W(32), .TAG_W(8),
        .MAX_OUTSTANDING(2), .CL_BYTES(128)
    ) dut_credit (
        .clock(clock), .rstn(rstn), .enabled_in(enabled), .job_start_in(b_job_start),
        .job_base_addr_in(job_base), .job_lines_in(job_lines),
        .ch_valid_in(ch_valid[1:0]), .ch_data_in(ch_data[2047:0]), .ch_ready_out(b_ready),
        .afu(ifb.master), .lines_issued_out(b_issued), .lines_done_out(b_lines_done),
        .busy_out(b_busy), .job_done_out(b_job_done), .error_out(b_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ifa.cmd_valid_out) begin
            addr_q.push_back(ifa.cmd_addr_out);
            tag_q.push_back(64'(ifa.cmd_tag_out));
            h0_q.push_back(64'(ifa.wdata_half0_out[31:0]));
            h1_q.push_back(64'(ifa.wdata_half1_out[31:0]));
        end
        if (job_done)          done_cnt   <= done_cnt + 1;
        if (ifb.cmd_valid_out) b_cnt      <= b_cnt + 1;
        if (b_job_done)        b_done_cnt <= b_done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic clear_q();
        addr_q.delete(); tag_q.delete(); h0_q.delete(); h1_q.delete();
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] lines);
        job_base  = base;
        job_lines = lines;
        job_start = 1'b1;
        tick(1);
        job_start = 1'b0;
    endtask

    task automatic wait_cmds(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && addr_q.size() < n; i++) tick(1);
        check_eq(tag, 64'(addr_q.size()), 64'(n));
    endtask

    task automatic wait_done(input int prev, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt == prev; i++) tick(1);
        tick(3);
        check_eq(tag, 64'(done_cnt - prev), 64'd1);
    endtask

    // fail_at selects which of the n responses reports a failed status (-1 for none).
    task automatic respond(input int n, input int fail_at);
        for (int k = 0; k < n; k++) begin
            ifa.resp_valid_in = 1'b1;
            ifa.resp_ok_in    = (k != fail_at);
            tick(1);
            ifa.resp_valid_in = 1'b0;
            ifa.resp_ok_in    = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n0;
        rstn = 1'b0; enabled = 1'b1; job_start = 1'b0; b_job_start = 1'b0;
        job_base = '0; job_lines = '0; ch_valid = '0; ch_data = '0;
        ifa.cmd_buffer_full_in = 1'b0; ifa.data_buffer_full_in = 1'b0;
        ifa.resp_valid_in = 1'b0; ifa.resp_ok_in = 1'b0;
        ifb.cmd_buffer_full_in = 1'b0; ifb.data_buffer_full_in = 1'b0;
        ifb.resp_valid_in = 1'b0; ifb.resp_ok_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ch_data[c*1024 +: 32]       = 32'hA0 + 32'(c);
            ch_data[c*1024 + 512 +: 32] = 32'hB0 + 32'(c);
        end
        tick(2);

        check_eq("rst_cmd_valid", 64'(ifa.cmd_valid_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(job_done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_issued", 64'(lines_issued), 64'd0);
        check_eq("rst_ready", 64'(ch_ready), 64'd0);
        rstn = 1'b1;
        tick(1);

        // single channel, 4 lines
        ch_valid = 4'b0001;
        clear_q();
        d0 = done_cnt;
        start_job(64'h1000, 32'd4);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_cmds(4, 20, "t1_cmd_count");
        for (int k = 0; k < 4 && k < addr_q.size(); k++) begin
            check_eq("t1_addr", addr_q[k], 64'h1000 + 64'(k) * 64'h80);
            check_eq("t1_tag", tag_q[k], 64'(k));
        end
        check_eq("t1_size", 64'(ifa.cmd_size_out), 64'd128);
        respond(4, -1);
        wait_done(d0, 10, "t1_done_pulse");
        check_eq("t1_lines_done", 64'(lines_done), 64'd4);
        check_eq("t1_lines_issued", 64'(lines_issued), 64'd4);
        check_eq("t1_error", 64'(error), 64'd0);
        check_eq("t1_idle", 64'(busy), 64'd0);

        // four channels, round-robin from reset
        do_reset();
        ch_valid = 4'b1111;
        clear_q();
        d0 = done_cnt;
        start_job(64'h2000, 32'd8);
        wait_cmds(8, 30, "t2_cmd_count");
        for (int k = 0; k < 8 && k < h0_q.size(); k++) begin
            check_eq("t2_grant_h0", h0_q[k], 64'hA0 + 64'(k % 4));
            check_eq("t2_grant_h1", h1_q[k], 64'hB0 + 64'(k % 4));
        end
        if (addr_q.size() == 8) check_eq("t2_last_addr", addr_q[7], 64'h2380);
        respond(8, -1);
        wait_done(d0, 10, "t2_done_pulse");

        // credit limit of 2 on the second instance
        ch_valid = 4'b0001;
        job_base = 64'h7000; job_lines = 32'd4;
        b_job_start = 1'b1;
        tick(1);
        b_job_start = 1'b0;
        tick(10);
        check_eq("t3_credit_stall", 64'(b_cnt), 64'd2);
        check_eq("t3_ready_low", 64'(b_ready), 64'd0);
        ifb.resp_valid_in = 1'b1; ifb.resp_ok_in = 1'b1;
        tick(1);
        ifb.resp_valid_in = 1'b0;
        tick(5);
        check_eq("t3_one_more", 64'(b_cnt), 64'd3);
        for (int k = 0; k < 3; k++) begin
            ifb.resp_valid_in = 1'b1;
            tick(1);
            ifb.resp_valid_in = 1'b0;
            tick(3);
        end
        check_eq("t3_all_issued", 64'(b_cnt), 64'd4);
        check_eq("t3_lines_done", 64'(b_lines_done), 64'd4);
        check_eq("t3_done_pulse", 64'(b_done_cnt), 64'd1);
        ifb.resp_ok_in = 1'b0;

        // command buffer backpressure and enable pause
        clear_q();
        d0 = done_cnt;
        ifa.cmd_buffer_full_in = 1'b1;
        start_job(64'h3000, 32'd6);
        tick(5);
        check_eq("t4_bp_hold", 64'(addr_q.size()), 64'd0);
        ifa.cmd_buffer_full_in = 1'b0;
        wait_cmds(2, 10, "t4_resume");
        enabled = 1'b0;
        tick(2);
        n0 = addr_q.size();
        tick(5);
        check_eq("t4_pause_hold", 64'(addr_q.size()), 64'(n0));
        check_eq("t4_pause_valid", 64'(ifa.cmd_valid_out), 64'd0);
        check_eq("t4_pause_busy", 64'(busy), 64'd1);
        enabled = 1'b1;
        wait_cmds(6, 20, "t4_cmd_count");
        for (int k = 0; k < 6 && k < addr_q.size(); k++)
            check_eq("t4_addr", addr_q[k], 64'h3000 + 64'(k) * 64'h80);
        respond(6, -1);
        wait_done(d0, 10, "t4_done_pulse");

        // failed response on the second line
        clear_q();
        d0 = done_cnt;
        start_job(64'h4000, 32'd3);
        wait_cmds(3, 15, "t5_cmd_count");
        respond(1, -1);
        check_eq("t5_err_before", 64'(error), 64'd0);
        respond(1, 0);
        check_eq("t5_err_set", 64'(error), 64'd1);
        respond(1, -1);
        check_eq("t5_err_sticky", 64'(error), 64'd1);
        wait_done(d0, 10, "t5_done_pulse");
        check_eq("t5_err_after_done", 64'(error), 64'd1);

        // zero-line job, which also clears the error flag
        clear_q();
        d0 = done_cnt;
        start_job(64'h5000, 32'd0);
        check_eq("t6_err_clear", 64'(error), 64'd0);
        check_eq("t6_busy", 64'(busy), 64'd1);
        wait_done(d0, 2, "t6_done_pulse");
        check_eq("t6_no_cmds", 64'(addr_q.size()), 64'd0);
        check_eq("t6_issued", 64'(lines_issued), 64'd0);

        // reset in the middle of a run
        clear_q();
        start_job(64'h6000, 32'd10);
        tick(3);
        #2 rstn = 1'b0;
        #1;
        check_eq("t7_rst_valid", 64'(ifa.cmd_valid_out), 64'd0);
        check_eq("t7_rst_issued", 64'(lines_issued), 64'd0);
        check_eq("t7_rst_busy", 64'(busy), 64'd0);
        check_eq("t7_rst_ready", 64'(ch_ready), 64'd0);
        tick(1);
        rstn = 1'b1;
        respond(1, -1);
        tick(1);
        check_eq("t7_late_resp", 64'(lines_done), 64'd0);
        check_eq("t7_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cu_data_write_engine_control_mc.md
# cu_data_write_engine_control_mc

Parametrised multi-channel write engine control for the CAPI compute unit. It accepts cacheline-sized write data from `NUM_CHANNELS` producer channels and arbitrates between them round-robin. For each accepted line it issues a sequentially addressed write command with a matching data line, and it bounds in-flight writes with a tag-credit limit. It tracks completions per job and sits between the CU datapath and the AFU write command and data buffers.

## Interface
Parameters:
- `NUM_CHANNELS`, 2: number of producer channels (1..8).
- `ADDR_W`, 64: effective-address width.
- `CNT_W`, 32: line counter width.
- `TAG_W`, 8: command tag width.
- `MAX_OUTSTANDING`, 8: in-flight write limit. Must be ≤ 2^TAG_W.
- `CL_BYTES`, 128: cacheline size in bytes. Each half is 512 bits.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are `clock` and `rstn`.
- `clock` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `enabled_in` in 1: global enable. When low, the block issues nothing.
- `job_start_in` in 1: one-cycle pulse that latches the job.
- `job_base_addr_in` in ADDR_W: job base address, cacheline aligned.
- `job_lines_in` in CNT_W: number of lines to write.
- `ch_valid_in` in NUM_CHANNELS: per-channel data valid.
- `ch_data_in` in NUM_CHANNELS*1024: per-channel line. Channel c occupies bits [c*1024 +: 1024].
- `ch_ready_out` out NUM_CHANNELS: per-channel accept. One-hot or zero.
- `cmd_buffer_full_in` in 1: command buffer almost-full.
- `data_buffer_full_in` in 1: data buffer almost-full.
- `cmd_valid_out` out 1: write command valid.
- `cmd_addr_out` out ADDR_W: write address.
- `cmd_tag_out` out TAG_W: write tag.
- `cmd_size_out` out 8: always CL_BYTES.
- `wdata_valid_out` out 1: data line valid. Coincident with `cmd_valid_out`.
- `wdata_half0_out` out 512: line bits [511:0].
- `wdata_half1_out` out 512: line bits [1023:512].
- `resp_valid_in` in 1: write response.
- `resp_ok_in` in 1: response status. 1 means DONE; 0 means failed.
- `lines_issued_out` out CNT_W: lines issued this job.
- `lines_done_out` out CNT_W: responses received this job.
- `busy_out` out 1: asserted in every state except IDLE.
- `job_done_out` out 1: one-cycle completion pulse.
- `error_out` out 1: sticky failed-response flag.

## Operation
- States and transitions:
  - IDLE: on `job_start_in` with `enabled_in` high, latch base and lines, clear counters and `error_out`, then go to RUN. If `job_lines_in` is 0, go straight to DONE instead.
  - RUN: issue lines. When `lines_issued_out` reaches the latched line count, go to DRAIN.
  - DRAIN: wait until outstanding = 0, then go to DONE.
  - DONE: assert `job_done_out` for one cycle, then return to IDLE.
- `job_start_in` is ignored outside IDLE.
- Issue eligibility (RUN only) requires all of the following:
  - `enabled_in` high.
  - both buffer-full inputs low.
  - outstanding < MAX_OUTSTANDING.
  - issued < lines.
  - at least one channel valid.
- Arbitration is round-robin. The search starts at the channel after the last grant; the pointer resets to 0. The granted channel gets `ch_ready_out` high in the same cycle, and the transfer happens when valid and ready are both high.
- Issued command fields:
  - address = base + issued × CL_BYTES, with arithmetic modulo 2^ADDR_W.
  - tag = issued[TAG_W-1:0].
- Outstanding counter:
  - +1 on issue, −1 on `resp_valid_in`.
  - Simultaneous issue and response leaves it unchanged.
- `resp_valid_in` increments `lines_done_out`. If `resp_ok_in` is 0, `error_out` is set and held until the next job start. Responses in IDLE are ignored.
- `enabled_in` dropping mid-job pauses issue only. Responses are still counted and DRAIN still completes.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Latency:
  - Command and data outputs are registered. A channel accepted in cycle N appears on `cmd_*` and `wdata_*` in cycle N+1.
  - Maximum throughput is one line per cycle.
- `job_done_out` fires one cycle after entering DONE, following the last response.
- Counters update the cycle after the causing event.
- Reset asserted mid-job clears everything asynchronously. In-flight responses that arrive afterwards are ignored because the state is IDLE.

## Test plan
- Single channel, base 0x1000, 4 lines, no backpressure:
  - Commands go to 0x1000, 0x1080, 0x1100, 0x1180 with tags 0–3.
  - 4 OK responses produce `lines_done_out` = 4, one `job_done_out` pulse, and `error_out` = 0.
- Four channels all valid, 8 lines:
  - Grants go 0,1,2,3,0,1,2,3.
  - Each line's data matches its channel.
- MAX_OUTSTANDING = 2 with responses withheld: exactly 2 issues, then `ch_ready_out` stays 0. One response allows one more issue.
- `cmd_buffer_full_in` pulsed and `enabled_in` dropped mid-job: no issues during either. The job still completes with the correct addresses.
- Response with `resp_ok_in` = 0 on line 2 of 3: `error_out` goes to 1 and stays, `job_done_out` still pulses, and `error_out` clears on the next job start.
- `job_lines_in` = 0: `job_done_out` pulses within 2 cycles and no commands are issued.
- Reset asserted mid-RUN: all outputs are 0 immediately, and a later response leaves `lines_done_out` at 0.
